// File: rtl/rx_sample_reader_pkg.sv
// Shared constants for the rx sample reader:
// words per complex sample and reader FSM state encoding.
package rx_sample_reader_pkg;

  localparam int RX_WORDS_PER_SAMPLE = 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GET_I  = 2'd1;
  localparam logic [1:0] ST_GET_Q  = 2'd2;
  localparam logic [1:0] ST_GET_HI = 2'd3;

endpackage

// File: rtl/sync_fifo16.sv
// Single-clock 16-bit FIFO, 2^DEPTH_LOG2 words, registered read port.
// Ports: push/din, pop -> dout/dout_valid, count, free, empty; clear flushes.
module sync_fifo16 #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  adc_clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic [15:0]           din,
  input  logic                  pop,
  output logic [15:0]           dout,
  output logic                  dout_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic [DEPTH_LOG2:0]   free,
  output logic                  empty
);

  localparam logic [DEPTH_LOG2:0] DEPTH =
    {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] CNT_ONE = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

  logic [15:0]           mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = count == '0;
  assign free    = DEPTH - count;
  assign do_push = push && !clear && count != DEPTH;
  assign do_pop  = pop && !clear && !empty;

  always_ff @(posedge adc_clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (clear) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= do_pop;
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop) begin
        rptr <= rptr + PTR_ONE;
        dout <= mem[rptr];
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rx_sample_reader.sv
// Reader end of the rx output interface: pulls I low, Q low, packed I/Q
// high bytes into a FIFO. Ports: rx strobe/data/selects, FIFO pop side, drops.
import rx_sample_reader_pkg::*;

module rx_sample_reader #(
  parameter int DEPTH_LOG2 = 9,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  adc_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  rx_avail_A,
  input  logic [15:0]           rx_dout_A,
  output logic                  rd_getI,
  output logic                  rd_getQ,
  input  logic                  fifo_rd,
  output logic [15:0]           fifo_dout,
  output logic                  fifo_dout_valid,
  output logic                  fifo_empty,
  output logic [DEPTH_LOG2:0]   fifo_words,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  localparam logic [DEPTH_LOG2:0] SAMPLE_WORDS =
    (DEPTH_LOG2+1)'(RX_WORDS_PER_SAMPLE);
  localparam logic [CNT_WIDTH-1:0] DROP_ONE = 1;

  logic [1:0]          state;
  logic [1:0]          state_nx;
  logic [DEPTH_LOG2:0] free_words;
  logic                strobe;
  logic                room;
  logic                drop;
  logic                push;

  // With both selects low the rx drives the packed high-byte word,
  // so every non-idle state pushes whatever rx_dout_A presents.
  assign strobe = rx_avail_A && enable;
  assign room   = free_words >= SAMPLE_WORDS;
  assign push   = state != ST_IDLE;
  assign drop   = strobe && (state != ST_IDLE || !room);

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (strobe && room) state_nx = ST_GET_I;
      ST_GET_I: state_nx = ST_GET_Q;
      ST_GET_Q: state_nx = ST_GET_HI;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      rd_getI    <= 1'b0;
      rd_getQ    <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      state      <= ST_IDLE;
      rd_getI    <= 1'b0;
      rd_getQ    <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      state   <= state_nx;
      rd_getI <= state_nx == ST_GET_I;
      rd_getQ <= state_nx == ST_GET_Q;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1)
          drop_count <= drop_count + DROP_ONE;
      end
    end
  end

  sync_fifo16 #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .adc_clk    (adc_clk),
    .reset      (reset),
    .clear      (clear),
    .push       (push),
    .din        (rx_dout_A),
    .pop        (fifo_rd),
    .dout       (fifo_dout),
    .dout_valid (fifo_dout_valid),
    .count      (fifo_words),
    .free       (free_words),
    .empty      (fifo_empty)
  );

endmodule

// File: tb/tb_rx_sample_reader.sv
// Bench for rx_sample_reader: queue model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rx_sample_reader;

  localparam int DL2   = 3;
  localparam int CW    = 2;
  localparam int DEPTH = 8;

  logic          adc_clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic          rx_avail_A = 1'b0;
  logic          fifo_rd = 1'b0;
  logic [15:0]   rx_dout_A;
  logic          rd_getI;
  logic          rd_getQ;
  logic [15:0]   fifo_dout;
  logic          fifo_dout_valid;
  logic          fifo_empty;
  logic [DL2:0]  fifo_words;
  logic          overflow;
  logic [CW-1:0] drop_count;

  logic [23:0]   cur_i = '0;
  logic [23:0]   cur_q = '0;
  int            n_vec = 0;
  int            n_err = 0;
  int            n_pops = 0;
  int            base;

  always #5 adc_clk = ~adc_clk;

  // rx source: word selected by the reader's select lines
  assign rx_dout_A = rd_getI ? cur_i[15:0] :
                     rd_getQ ? cur_q[15:0] :
                     {cur_i[23:16], cur_q[23:16]};

  rx_sample_reader #(
    .DEPTH_LOG2 (DL2),
    .CNT_WIDTH  (CW)
  ) dut (
    .adc_clk         (adc_clk),
    .reset           (reset),
    .enable          (enable),
    .clear           (clear),
    .rx_avail_A      (rx_avail_A),
    .rx_dout_A       (rx_dout_A),
    .rd_getI         (rd_getI),
    .rd_getQ         (rd_getQ),
    .fifo_rd         (fifo_rd),
    .fifo_dout       (fifo_dout),
    .fifo_dout_valid (fifo_dout_valid),
    .fifo_empty      (fifo_empty),
    .fifo_words      (fifo_words),
    .overflow        (overflow),
    .drop_count      (drop_count)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: queue of words, words still owed by the
  // current sample, and drop bookkeeping.
  logic [15:0] mq[$];
  logic [15:0] m_words [3];
  int          m_pend;
  int          m_occ;
  bit          m_busy;
  bit          m_ovf;
  int          m_drops;
  bit          m_valid;
  logic [15:0] m_dout;

  always @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_pend = 0;
      m_ovf = 0;
      m_drops = 0;
      m_valid = 0;
      m_dout = '0;
    end else if (clear) begin
      mq.delete();
      m_pend = 0;
      m_ovf = 0;
      m_drops = 0;
      m_valid = 0;
    end else begin
      m_occ = mq.size();
      m_busy = m_pend > 0;
      m_valid = 0;
      if (fifo_rd && m_occ > 0) begin
        m_dout = mq.pop_front();
        m_valid = 1;
      end
      if (m_busy) begin
        mq.push_back(m_words[3-m_pend]);
        m_pend--;
      end
      if (rx_avail_A && enable) begin
        if (!m_busy && DEPTH - m_occ >= 3) begin
          m_words[0] = cur_i[15:0];
          m_words[1] = cur_q[15:0];
          m_words[2] = {cur_i[23:16], cur_q[23:16]};
          m_pend = 3;
        end else begin
          m_ovf = 1;
          if (m_drops < (1 << CW) - 1) m_drops++;
        end
      end
    end
  end

  always @(negedge adc_clk) begin
    if (!reset) begin
      chk("fifo_words", 32'(fifo_words), 32'(mq.size()));
      chk("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
      chk("dout_valid", 32'(fifo_dout_valid), 32'(m_valid));
      if (m_valid) chk("fifo_dout", 32'(fifo_dout), 32'(m_dout));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("drop_count", 32'(drop_count), 32'(m_drops));
      chk("rd_getI", 32'(rd_getI), 32'(m_pend == 3));
      chk("rd_getQ", 32'(rd_getQ), 32'(m_pend == 2));
    end
  end

  always @(negedge adc_clk) begin
    if (fifo_dout_valid) n_pops++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge adc_clk);
  endtask

  task automatic strobe(input logic [23:0] i,
                        input logic [23:0] q);
    @(negedge adc_clk);
    cur_i = i;
    cur_q = q;
    rx_avail_A = 1'b1;
    @(negedge adc_clk);
    rx_avail_A = 1'b0;
  endtask

  task automatic pulse();
    @(negedge adc_clk);
    rx_avail_A = 1'b1;
    @(negedge adc_clk);
    rx_avail_A = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge adc_clk);
    clear = 1'b1;
    @(negedge adc_clk);
    clear = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    tick(2);
    chk("rst_words", 32'(fifo_words), 0);
    chk("rst_empty", 32'(fifo_empty), 1);
    chk("rst_dout", 32'(fifo_dout), 0);
    chk("rst_valid", 32'(fifo_dout_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drops", 32'(drop_count), 0);
    chk("rst_sel", 32'({rd_getI, rd_getQ}), 0);
    #1 reset = 1'b0;
    enable = 1'b1;
    tick(2);

    // single sample
    strobe(24'h123456, 24'hABCDEF);
    chk("s1_getI", 32'(rd_getI), 1);
    tick(1);
    chk("s1_getQ", 32'(rd_getQ), 1);
    chk("s1_getI_low", 32'(rd_getI), 0);
    tick(2);
    chk("s1_words", 32'(fifo_words), 3);
    fifo_rd = 1'b1;
    tick(1);
    chk("s1_v0", 32'(fifo_dout_valid), 1);
    chk("s1_w0", 32'(fifo_dout), 32'h3456);
    tick(1);
    chk("s1_w1", 32'(fifo_dout), 32'hCDEF);
    tick(1);
    chk("s1_w2", 32'(fifo_dout), 32'h12AB);
    fifo_rd = 1'b0;
    tick(1);
    chk("s1_v_end", 32'(fifo_dout_valid), 0);
    chk("s1_empty", 32'(fifo_empty), 1);

    // back-to-back strobes at cycles 0 and 2
    strobe(24'h0A0B0C, 24'h0D0E0F);
    pulse();
    tick(3);
    chk("b2b_drops", 32'(drop_count), 1);
    chk("b2b_ovf", 32'(overflow), 1);
    chk("b2b_words", 32'(fifo_words), 3);
    fifo_rd = 1'b1;
    tick(3);
    chk("b2b_last", 32'(fifo_dout), 32'h0A0D);
    fifo_rd = 1'b0;
    tick(1);

    // clear during GET_Q
    strobe(24'h7F8001, 24'h807FFE);
    @(negedge adc_clk);
    clear = 1'b1;
    @(negedge adc_clk);
    clear = 1'b0;
    chk("clr_words", 32'(fifo_words), 0);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_drops", 32'(drop_count), 0);
    chk("clr_sel", 32'({rd_getI, rd_getQ}), 0);
    tick(2);
    strobe(24'h00FF00, 24'hFF00FF);
    tick(3);
    chk("clr_next", 32'(fifo_words), 3);

    // clear with same-cycle pop
    @(negedge adc_clk);
    clear = 1'b1;
    fifo_rd = 1'b1;
    @(negedge adc_clk);
    clear = 1'b0;
    fifo_rd = 1'b0;
    chk("clrpop_valid", 32'(fifo_dout_valid), 0);
    chk("clrpop_words", 32'(fifo_words), 0);
    tick(1);

    // fill an 8-word FIFO, then saturate the counter
    strobe(24'h010203, 24'h040506);
    tick(8);
    strobe(24'h111213, 24'h141516);
    tick(8);
    strobe(24'h212223, 24'h242526);
    tick(8);
    chk("fill_words", 32'(fifo_words), 6);
    chk("fill_ovf", 32'(overflow), 1);
    chk("fill_drops", 32'(drop_count), 1);
    for (int k = 0; k < 4; k++) begin
      pulse();
      tick(2);
    end
    chk("sat_drops", 32'(drop_count), 3);

    // drain, then one pop against an empty FIFO
    fifo_rd = 1'b1;
    tick(7);
    chk("mt_valid", 32'(fifo_dout_valid), 0);
    chk("mt_words", 32'(fifo_words), 0);
    fifo_rd = 1'b0;

    // enable low mid-capture and for later strobes
    do_clear();
    strobe(24'h5A5A5A, 24'hA5A5A5);
    enable = 1'b0;
    pulse();
    tick(4);
    chk("en_words", 32'(fifo_words), 3);
    chk("en_drops", 32'(drop_count), 0);
    enable = 1'b1;
    fifo_rd = 1'b1;
    tick(4);
    fifo_rd = 1'b0;

    // pointer wrap with concurrent pops
    do_clear();
    base = n_pops;
    fifo_rd = 1'b1;
    for (int k = 0; k < 20; k++) begin
      strobe({8'(k + 1), 16'(k * 4099)},
             {8'(8'hF0 ^ k), 16'(k * 257 + 5)});
      tick(2);
    end
    tick(6);
    fifo_rd = 1'b0;
    chk("wrap_pops", 32'(n_pops - base), 60);
    chk("wrap_drops", 32'(drop_count), 0);
    chk("wrap_empty", 32'(fifo_empty), 1);

    // reset mid-capture
    strobe(24'h13579B, 24'h2468AC);
    #1 reset = 1'b1;
    @(negedge adc_clk);
    chk("mrst_words", 32'(fifo_words), 0);
    chk("mrst_sel", 32'({rd_getI, rd_getQ}), 0);
    chk("mrst_valid", 32'(fifo_dout_valid), 0);
    #1 reset = 1'b0;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rx_sample_reader.md
Name: rx_sample_reader

Overview:
- Reader end of the rx channel output interface.
- On each rx_avail_A strobe it sequences rd_getI / rd_getQ to pull one complex sample as three 16-bit words: I low, Q low, then the packed I/Q high bytes.
- Words go into an internal FIFO that the CPU-side data path drains.
- Sits between one rx instance and the host sample transfer logic, entirely in the adc_clk domain.

Parameters:
- DEPTH_LOG2, 9: FIFO depth is 2^DEPTH_LOG2 16-bit words (512).
- CNT_WIDTH, 16: width of the dropped-sample counter.

Ports:
- adc_clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  capture enable; when low, rx_avail_A strobes are ignored and not counted.
- clear  in  1  synchronous: flush FIFO, clear overflow and counters.
- rx_avail_A  in  1  one-cycle strobe from rx; new sample valid.
- rx_dout_A  in  16  combinational word from rx, selected by rd_getI / rd_getQ.
- rd_getI  out  1  select I low word.
- rd_getQ  out  1  select Q low word.
- fifo_rd  in  1  pop one word.
- fifo_dout  out  16  popped word, registered.
- fifo_dout_valid  out  1  one-cycle pulse accompanying fifo_dout.
- fifo_empty  out  1  FIFO holds zero words.
- fifo_words  out  DEPTH_LOG2+1  current occupancy.
- overflow  out  1  sticky; set when a sample is dropped.
- drop_count  out  CNT_WIDTH  samples dropped, saturating.

Behaviour:
- Reset values:
  - FSM in IDLE; rd_getI=0, rd_getQ=0.
  - FIFO empty: fifo_words=0, fifo_empty=1.
  - fifo_dout=0, fifo_dout_valid=0.
  - overflow=0, drop_count=0.
- FSM states: IDLE, GET_I, GET_Q, GET_HI.
- In IDLE, rx_avail_A && enable:
  - If free words >= 3, go to GET_I.
  - Otherwise stay in IDLE, set overflow, increment drop_count (saturating at all-ones).
  - Free words are computed from occupancy before any same-cycle pop.
- GET_I: rd_getI=1, rd_getQ=0. Push rx_dout_A (I[15:0]) this cycle; next state GET_Q.
- GET_Q: rd_getI=0, rd_getQ=1. Push Q[15:0]; next state GET_HI.
- GET_HI: rd_getI=0, rd_getQ=0. Push {I[MSB-:8], Q[MSB-:8]}; next state IDLE.
- rd_getI / rd_getQ are registered outputs decoded from the state; they are never both high.
- Capture latency: word 1 is pushed in the cycle after rx_avail_A; all 3 words are in the FIFO 3 cycles after the strobe.
- Samples are atomic: all 3 words or none. Space is reserved in IDLE, so the FIFO can never fill mid-sample.
- rx_avail_A while not in IDLE (back-to-back strobes closer than 4 cycles):
  - Treated as a dropped sample: overflow set, drop_count incremented.
  - The in-progress capture is unaffected.
- FIFO storage:
  - Circular buffer with write and read pointers of DEPTH_LOG2 bits that wrap naturally.
  - Occupancy is kept in a DEPTH_LOG2+1 bit counter.
- Pop:
  - fifo_rd with fifo_empty=0: fifo_dout and fifo_dout_valid update 1 cycle later.
  - fifo_rd with fifo_empty=1: ignored, no valid pulse, pointers unchanged.
- Simultaneous push and pop in one cycle: occupancy unchanged; both pointers advance.
- clear:
  - Highest priority.
  - Next cycle: pointers zero, occupancy 0, overflow=0, drop_count=0, FSM in IDLE, rd_getI/rd_getQ low.
  - A sample capture in progress is abandoned; its partial words are discarded.
  - A pop in the same cycle produces no valid pulse.
- enable deasserted mid-capture: the current sample completes; later strobes are ignored.
- reset asserted mid-operation: immediate return to reset values; RAM contents are don't-care.

Decomposition:
- Shared package constants:
  - RX_WORDS_PER_SAMPLE = 3.
  - Reader FSM state encoding (2 bits).
- One natural sub-module: sync_fifo16. Single-clock, parameterised by DEPTH_LOG2, with push, pop, count and a registered read port. Free space is exposed as (2^DEPTH_LOG2 - count).

Test Plan:
- Single sample: I=0x1234_56 (24-bit I, low word 0x3456, high byte 0x12), Q=0xABCD_EF (low word 0xCDEF, high byte 0xAB); pulse rx_avail_A -> rd_getI high at +1, rd_getQ high at +2; FIFO words 0x3456, 0xCDEF, 0x12AB; fifo_words=3 at +4; 3 pops return them in order with valid pulses.
- Fill: DEPTH_LOG2=3 (8 words), 3 strobes spaced 10 cycles, no reads -> 2 samples stored (fifo_words=6); 3rd dropped, overflow=1, drop_count=1.
- Back-to-back: strobes at cycles 0 and 2 -> first sample captured intact, second counted as dropped, drop_count=1.
- Wrap: DEPTH_LOG2=3, continuous capture with concurrent pops for 20 samples -> 60 words read in order, no drops, pointers wrapped several times.
- Clear mid-capture: assert clear during GET_Q -> next cycle fifo_words=0, overflow=0, selects low; next strobe captures normally.
- Pop when empty, saturation: pop with empty FIFO -> no valid pulse, count stays 0; CNT_WIDTH=2 with 5 drops -> drop_count=3.
